// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, types and the forward S-box table
package aes_pkg;
  localparam int STATE_W = 128;
  localparam int BYTE_W = 8;
  localparam int NUM_BYTES = STATE_W / BYTE_W;
  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [STATE_W-1:0] state_t;
  // Forward S-box, indexed by input byte; also reused by key-expansion SubWord
  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational forward S-box lookup for one byte
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t value,
  output byte_t result
);
  assign result = SBOX[value];
endmodule

// File: rtl/sub_bytes.sv
// sub_bytes: registered AES SubBytes stage, one state per clock, 1-cycle latency
module sub_bytes
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [STATE_W-1:0] current_state,
  output logic               out_valid,
  output logic [STATE_W-1:0] new_state
);
  state_t sub;
  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
    aes_sbox u_sbox (
      .value  (current_state[STATE_W-1-BYTE_W*i -: BYTE_W]),
      .result (sub[STATE_W-1-BYTE_W*i -: BYTE_W])
    );
  end
  // capture substituted state on valid, otherwise hold it for downstream
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      new_state <= '0;
    end else begin
      out_valid <= in_valid;
      new_state <= in_valid ? sub : new_state;
    end
  end
endmodule

// File: tb/tb_sub_bytes.sv
// tb_sub_bytes: directed self-checking bench for sub_bytes
module tb_sub_bytes;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] current_state = '0;
  logic         out_valid;
  logic [127:0] new_state;
  int passed = 0;
  int total = 0;

  localparam logic [127:0] R1_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] R1_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] R2_IN  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] R2_OUT = 128'h49ded28945db96f17f39871a7702533b;
  localparam logic [127:0] R3_IN  = 128'haa8f5f0361dde3ef82d24ad26832469a;
  localparam logic [127:0] R3_OUT = 128'hac73cf7befc111df13b5d6b545235ab8;

  sub_bytes dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .current_state (current_state),
    .out_valid     (out_valid),
    .new_state     (new_state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] v);
    logic [7:0] r = 8'h01;
    logic [7:0] s;
    for (int k = 0; k < 254; k++) r = gmul(r, v);
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic v, input logic [127:0] d);
    rst_n = r;
    in_valid = v;
    current_state = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] e;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, R1_IN);
    chk("reset_state", new_state, '0);
    chk("reset_valid", {127'd0, out_valid}, 128'd0);
    step(1'b1, 1'b1, R1_IN);
    chk("r1_valid", {127'd0, out_valid}, 128'd1);
    chk("r1_data", new_state, R1_OUT);
    step(1'b1, 1'b1, R2_IN);
    chk("r2_valid", {127'd0, out_valid}, 128'd1);
    chk("r2_data", new_state, R2_OUT);
    step(1'b1, 1'b1, R3_IN);
    chk("r3_valid", {127'd0, out_valid}, 128'd1);
    chk("r3_data", new_state, R3_OUT);
    step(1'b1, 1'b1, R1_IN);
    step(1'b1, 1'b0, R2_IN);
    chk("hold_valid", {127'd0, out_valid}, 128'd0);
    chk("hold_data", new_state, R1_OUT);
    step(1'b1, 1'b0, R3_IN);
    chk("hold_data2", new_state, R1_OUT);
    step(1'b1, 1'b1, R3_IN);
    chk("pre_rst_data", new_state, R3_OUT);
    step(1'b0, 1'b1, R1_IN);
    chk("mid_rst_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_data", new_state, '0);
    step(1'b1, 1'b1, R2_IN);
    chk("post_rst_valid", {127'd0, out_valid}, 128'd1);
    chk("post_rst_data", new_state, R2_OUT);
    step(1'b1, 1'b1, {16{8'h00}});
    chk("spot_00", new_state, {16{8'h63}});
    step(1'b1, 1'b1, {16{8'h53}});
    chk("spot_53", new_state, {16{8'hed}});
    step(1'b1, 1'b1, {16{8'hff}});
    chk("spot_ff", new_state, {16{8'h16}});
    step(1'b1, 1'b1, 128'h0001_5319_3de3_beff_0001_5319_3de3_beff);
    chk("anchors", new_state, 128'h637c_edd4_2711_ae16_637c_edd4_2711_ae16);
    for (int v = 0; v < 256; v++) begin
      step(1'b1, 1'b1, {16{8'(v)}});
      e = sbox_ref(8'(v));
      chk($sformatf("lane_%02h", v), new_state, {16{e}});
    end
    chk("final_valid", {127'd0, out_valid}, 128'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
